// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types and encodings for the multicycle core control FSM.
// Field encodings match the datapath mux and ALU-control decoder inputs.
package multicycle_control_fsm_pkg;

   typedef enum logic [3:0] {
      S_WAIT     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC_R   = 4'd7,
      S_R_WB     = 4'd8,
      S_EXEC_I   = 4'd9,
      S_I_WB     = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12
   } ctrl_state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main control sequencer for the multicycle MIPS-subset core.
// Outputs decode from the current state, with mem_ready gating the fetch strobes.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int RESET_PC_HOLD = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [0:5] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcWrite,
   output logic       pcWriteCond,
   output logic       iorD,
   output logic       memRead,
   output logic       memWrite,
   output logic       irWrite,
   output logic       memToReg,
   output logic       regDst,
   output logic       regWrite,
   output logic       aluSrcA,
   output logic [0:1] aluSrcB,
   output logic [0:1] aluOp,
   output logic [0:1] pcSource,
   output logic       illegal_op,
   output logic [0:3] state_o
);

   localparam ctrl_state_t RESET_STATE = (RESET_PC_HOLD > 0) ? S_WAIT : S_FETCH;
   localparam int HOLD_W = (RESET_PC_HOLD > 1) ? $clog2(RESET_PC_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (RESET_PC_HOLD > 0) ? HOLD_W'(RESET_PC_HOLD - 1) : '0;

   ctrl_state_t       state_reg, state_next;
   logic [HOLD_W-1:0] hold_reg, hold_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RESET_STATE;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
      end
   end

   always_comb begin
      state_next = S_FETCH;
      hold_next  = hold_reg;
      case (state_reg)
         S_WAIT: begin
            if (hold_reg == HOLD_LAST) begin
               state_next = S_FETCH;
               hold_next  = '0;
            end else begin
               state_next = S_WAIT;
               hold_next  = hold_reg + 1'b1;
            end
         end
         S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_next = S_MEM_ADDR;
               OP_R:         state_next = S_EXEC_R;
               OP_BEQ:       state_next = S_BRANCH;
               OP_J:         state_next = S_JUMP;
               OP_ADDI:      state_next = S_EXEC_I;
               default:      state_next = S_FETCH;
            endcase
         end
         // IR is held stable, so the opcode still separates loads from stores here
         S_MEM_ADDR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR:   state_next = mem_ready ? S_FETCH : S_MEM_WR;
         S_EXEC_R:   state_next = S_R_WB;
         S_EXEC_I:   state_next = S_I_WB;
         default:    state_next = S_FETCH;
      endcase
   end

   always_comb begin
      pcWrite     = 1'b0;
      pcWriteCond = 1'b0;
      iorD        = 1'b0;
      memRead     = 1'b0;
      memWrite    = 1'b0;
      irWrite     = 1'b0;
      memToReg    = 1'b0;
      regDst      = 1'b0;
      regWrite    = 1'b0;
      aluSrcA     = 1'b0;
      aluSrcB     = SRCB_REG;
      aluOp       = ALUOP_ADD;
      pcSource    = PCSRC_ALU;
      illegal_op  = 1'b0;
      // Reset masks everything so no strobe leaks while the state is being forced
      if (!rst) begin
         case (state_reg)
            S_FETCH: begin
               memRead = 1'b1;
               aluSrcB = SRCB_FOUR;
               irWrite = mem_ready;
               pcWrite = mem_ready;
            end
            S_DECODE: begin
               aluSrcB = SRCB_IMM_SH;
               case (opcode)
                  OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                  default:                                   illegal_op = 1'b1;
               endcase
            end
            S_MEM_ADDR, S_EXEC_I: begin
               aluSrcA = 1'b1;
               aluSrcB = SRCB_IMM;
            end
            S_MEM_RD: begin
               memRead = 1'b1;
               iorD    = 1'b1;
            end
            S_MEM_WB: begin
               regWrite = 1'b1;
               memToReg = 1'b1;
            end
            S_MEM_WR: begin
               memWrite = 1'b1;
               iorD     = 1'b1;
            end
            S_EXEC_R: begin
               aluSrcA = 1'b1;
               aluOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
               regWrite = 1'b1;
               regDst   = 1'b1;
            end
            S_I_WB: regWrite = 1'b1;
            S_BRANCH: begin
               aluSrcA     = 1'b1;
               aluOp       = ALUOP_SUB;
               pcWriteCond = 1'b1;
               pcSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               pcWrite  = 1'b1;
               pcSource = PCSRC_JUMP;
            end
            default: ;
         endcase
      end
   end

   // The branch decision (pcWriteCond & zero) is formed in the datapath
   logic unused_zero;
   assign unused_zero = zero;

   assign state_o = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed and random checks of the multicycle control FSM sequencing.
module tb_multicycle_control_fsm;

   localparam logic [3:0] S_WAIT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                          S_MEM_RD = 4'd4, S_MEM_WR = 4'd6, S_EXEC_R = 4'd7, S_R_WB = 4'd8,
                          S_EXEC_I = 4'd9, S_BRANCH = 4'd11, S_LAST = 4'd12;
   localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                          OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

   logic       clk = 1'b0;
   logic       rst, zero, mem_ready;
   logic [0:5] opcode;
   logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic       memToReg, regDst, regWrite, aluSrcA, illegal_op;
   logic [0:1] aluSrcB, aluOp, pcSource;
   logic [0:3] state_o;
   logic       pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, irWrite2;
   logic       memToReg2, regDst2, regWrite2, aluSrcA2, illegal_op2;
   logic [0:1] aluSrcB2, aluOp2, pcSource2;
   logic [0:3] state_o2;
   logic [15:0] strobes2;

   int errors = 0;
   int checks = 0;

   multicycle_control_fsm dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
      .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .pcSource(pcSource), .illegal_op(illegal_op), .state_o(state_o)
   );

   multicycle_control_fsm #(.RESET_PC_HOLD(2)) dut_hold (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .iorD(iorD2), .memRead(memRead2),
      .memWrite(memWrite2), .irWrite(irWrite2), .memToReg(memToReg2), .regDst(regDst2),
      .regWrite(regWrite2), .aluSrcA(aluSrcA2), .aluSrcB(aluSrcB2), .aluOp(aluOp2),
      .pcSource(pcSource2), .illegal_op(illegal_op2), .state_o(state_o2)
   );

   assign strobes2 = {pcWrite2, pcWriteCond2, iorD2, memRead2, memWrite2, irWrite2, memToReg2,
                      regDst2, regWrite2, aluSrcA2, aluSrcB2, aluOp2, pcSource2, illegal_op2};

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Runs one instruction from FETCH back to FETCH, holding mem_ready low for
   // fw cycles in FETCH and mw cycles in MEM_RD/MEM_WR, and tallies strobes.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z,
                            output int cyc, output int irw, output int ill, output int regw,
                            output int memw, output int gap, output logic [1:0] wb_sel,
                            output logic [1:0] srcb);
      int fcnt = 0, mcnt = 0;
      bit left = 0;
      cyc = 0; irw = 0; ill = 0; regw = 0; memw = 0; gap = 0; wb_sel = 2'b11; srcb = 2'b11;
      opcode = op;
      zero   = z;
      while (!(left && state_o == S_FETCH) && cyc < 100) begin
         if (state_o == S_FETCH) begin
            mem_ready = (fcnt >= fw);
            fcnt++;
         end else if (state_o == S_MEM_RD || state_o == S_MEM_WR) begin
            mem_ready = (mcnt >= mw);
            mcnt++;
         end else begin
            mem_ready = 1'b1;
         end
         #1;
         if (irWrite) irw++;
         if (illegal_op) ill++;
         if (memWrite) memw++;
         if (regWrite) begin
            regw++;
            wb_sel = {regDst, memToReg};
         end
         if ((state_o == S_FETCH || state_o == S_MEM_RD) && !memRead) gap++;
         if (state_o == S_MEM_ADDR || state_o == S_EXEC_I) srcb = aluSrcB;
         if (state_o != S_FETCH) left = 1;
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 100) begin
         errors++;
         $display("FAIL run_timeout op=%b: no return to FETCH within 100 cycles", op);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (state_o !== S_FETCH) begin errors++; $display("FAIL reset_state got=%0d want=%0d", state_o, S_FETCH); end
      checks++;
      if ({memRead, irWrite, pcWrite, aluSrcB, aluOp} !== 7'b0) begin
         errors++; $display("FAIL reset_outputs got=%b want=0000000", {memRead, irWrite, pcWrite, aluSrcB, aluOp});
      end
      checks++;
      if (state_o2 !== S_WAIT || strobes2 !== 16'h0) begin
         errors++; $display("FAIL reset_hold got state=%0d strobes=%h want state=0 strobes=0000", state_o2, strobes2);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({memRead, irWrite, pcWrite, aluSrcB} !== 5'b10001) begin
         errors++; $display("FAIL fetch_stall got=%b want=10001", {memRead, irWrite, pcWrite, aluSrcB});
      end
      tick();
      checks++;
      if (state_o2 !== S_WAIT || strobes2 !== 16'h0) begin
         errors++; $display("FAIL hold_wait1 got state=%0d strobes=%h want state=0 strobes=0000", state_o2, strobes2);
      end
      tick();
      checks++;
      if (state_o2 !== S_FETCH || memRead2 !== 1'b1) begin
         errors++; $display("FAIL hold_release got state=%0d memRead=%b want state=1 memRead=1", state_o2, memRead2);
      end
      checks++;
      if (state_o !== S_FETCH) begin errors++; $display("FAIL fetch_hold got=%0d want=%0d", state_o, S_FETCH); end
   endtask

   task automatic test_r_type();
      mem_ready = 1'b1; opcode = OP_R;
      #1;
      checks++;
      if ({irWrite, pcWrite, memRead, iorD, aluSrcA, pcSource} !== 7'b1110000) begin
         errors++; $display("FAIL r_fetch got=%b want=1110000", {irWrite, pcWrite, memRead, iorD, aluSrcA, pcSource});
      end
      tick();
      checks++;
      if (state_o !== S_DECODE || aluSrcB !== 2'b11 || aluOp !== 2'b00 || aluSrcA !== 1'b0) begin
         errors++; $display("FAIL r_decode got state=%0d srcB=%b op=%b want state=2 srcB=11 op=00", state_o, aluSrcB, aluOp);
      end
      tick();
      checks++;
      if (state_o !== S_EXEC_R || aluOp !== 2'b10 || aluSrcA !== 1'b1 || aluSrcB !== 2'b00) begin
         errors++; $display("FAIL r_exec got state=%0d aluOp=%b srcA=%b srcB=%b want 7/10/1/00", state_o, aluOp, aluSrcA, aluSrcB);
      end
      tick();
      checks++;
      if (state_o !== S_R_WB || {regWrite, regDst, memToReg, memWrite} !== 4'b1100) begin
         errors++; $display("FAIL r_wb got state=%0d wb=%b want state=8 wb=1100", state_o, {regWrite, regDst, memToReg, memWrite});
      end
      tick();
      checks++;
      if (state_o !== S_FETCH) begin errors++; $display("FAIL r_latency got=%0d want=%0d after 4 cycles", state_o, S_FETCH); end
   endtask

   task automatic test_latencies();
      int cyc, irw, ill, regw, memw, gap;
      logic [1:0] wb, srcb;
      run_instr(OP_LW, 2, 3, 1'b0, cyc, irw, ill, regw, memw, gap, wb, srcb);
      checks++;
      if (cyc !== 10 || irw !== 1 || gap !== 0) begin
         errors++; $display("FAIL lw_wait got cycles=%0d irWrite=%0d readgap=%0d want 10/1/0", cyc, irw, gap);
      end
      checks++;
      if (regw !== 1 || wb !== 2'b01 || srcb !== 2'b10 || memw !== 0) begin
         errors++; $display("FAIL lw_ctrl got regw=%0d wb=%b srcB=%b memw=%0d want 1/01/10/0", regw, wb, srcb, memw);
      end
      run_instr(OP_LW, 0, 0, 1'b0, cyc, irw, ill, regw, memw, gap, wb, srcb);
      checks++;
      if (cyc !== 5) begin errors++; $display("FAIL lw_latency got=%0d want=5", cyc); end
      run_instr(OP_SW, 0, 1, 1'b0, cyc, irw, ill, regw, memw, gap, wb, srcb);
      checks++;
      if (cyc !== 5 || memw !== 2 || regw !== 0 || srcb !== 2'b10) begin
         errors++; $display("FAIL sw_wait got cycles=%0d memw=%0d regw=%0d srcB=%b want 5/2/0/10", cyc, memw, regw, srcb);
      end
      run_instr(OP_ADDI, 0, 0, 1'b0, cyc, irw, ill, regw, memw, gap, wb, srcb);
      checks++;
      if (cyc !== 4 || regw !== 1 || wb !== 2'b00 || srcb !== 2'b10) begin
         errors++; $display("FAIL addi got cycles=%0d regw=%0d wb=%b srcB=%b want 4/1/00/10", cyc, regw, wb, srcb);
      end
      run_instr(OP_J, 1, 0, 1'b0, cyc, irw, ill, regw, memw, gap, wb, srcb);
      checks++;
      if (cyc !== 4 || regw !== 0 || memw !== 0 || irw !== 1) begin
         errors++; $display("FAIL jump got cycles=%0d regw=%0d memw=%0d irw=%0d want 4/0/0/1", cyc, regw, memw, irw);
      end
      run_instr(6'b111111, 0, 0, 1'b0, cyc, irw, ill, regw, memw, gap, wb, srcb);
      checks++;
      if (cyc !== 2 || ill !== 1 || regw !== 0 || memw !== 0) begin
         errors++; $display("FAIL illegal got cycles=%0d pulses=%0d regw=%0d memw=%0d want 2/1/0/0", cyc, ill, regw, memw);
      end
      run_instr(6'b000001, 0, 0, 1'b0, cyc, irw, ill, regw, memw, gap, wb, srcb);
      checks++;
      if (cyc !== 2 || ill !== 1) begin errors++; $display("FAIL illegal2 got cycles=%0d pulses=%0d want 2/1", cyc, ill); end
   endtask

   task automatic test_beq();
      for (int i = 0; i < 2; i++) begin
         mem_ready = 1'b1; opcode = OP_BEQ; zero = (i == 0);
         tick();
         tick();
         checks++;
         if (state_o !== S_BRANCH || {aluOp, pcWriteCond, pcSource, aluSrcA, aluSrcB, pcWrite} !== 9'b011011000) begin
            errors++; $display("FAIL beq_z%0d got state=%0d ctrl=%b want state=11 ctrl=011011000", zero, state_o,
                               {aluOp, pcWriteCond, pcSource, aluSrcA, aluSrcB, pcWrite});
         end
         tick();
         checks++;
         if (state_o !== S_FETCH) begin errors++; $display("FAIL beq_latency_z%0d got=%0d want=%0d", zero, state_o, S_FETCH); end
      end
   endtask

   task automatic test_reset_mid_sw();
      mem_ready = 1'b1; opcode = OP_SW;
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      checks++;
      if (state_o !== S_MEM_WR || memWrite !== 1'b1 || iorD !== 1'b1) begin
         errors++; $display("FAIL sw_memwr got state=%0d memWrite=%b iorD=%b want 6/1/1", state_o, memWrite, iorD);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (memWrite !== 1'b0 || state_o !== S_FETCH) begin
         errors++; $display("FAIL async_reset got memWrite=%b state=%0d want 0/1", memWrite, state_o);
      end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (state_o !== S_FETCH || memRead !== 1'b1 || memWrite !== 1'b0 || regWrite !== 1'b0) begin
         errors++; $display("FAIL after_reset got state=%0d rd=%b wr=%b rw=%b want 1/1/0/0", state_o, memRead, memWrite, regWrite);
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [8];
      logic prev_ill = 1'b0;
      ops[0] = OP_R; ops[1] = OP_LW; ops[2] = OP_SW; ops[3] = OP_BEQ;
      ops[4] = OP_J; ops[5] = OP_ADDI; ops[6] = 6'b111111; ops[7] = 6'b010101;
      for (int n = 0; n < 10000; n++) begin
         opcode    = ops[$urandom_range(0, 7)];
         mem_ready = 1'($urandom_range(0, 1));
         zero      = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if ((memRead && memWrite) || (regWrite && memWrite)) begin
            errors++; $display("FAIL rand_excl cycle=%0d got rd=%b wr=%b rw=%b want no overlap", n, memRead, memWrite, regWrite);
         end
         checks++;
         if (prev_ill && illegal_op) begin
            errors++; $display("FAIL rand_illegal cycle=%0d got 2-cycle pulse want 1", n);
         end
         checks++;
         if (state_o > S_LAST) begin
            errors++; $display("FAIL rand_state cycle=%0d got=%0d want<=12", n, state_o);
         end
         prev_ill = illegal_op;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_latencies();
      test_beq();
      test_reset_mid_sw();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
